// File: rtl/washer_pkg.sv
// Shared encodings for the washer sequencer: FSM state codes and program modes.
package washer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FILL   = 4'd1,
    ST_REST_A = 4'd2,
    ST_FWD    = 4'd3,
    ST_REST_B = 4'd4,
    ST_REV    = 4'd5,
    ST_DRAIN  = 4'd6,
    ST_SPIN   = 4'd7,
    ST_DONE   = 4'd8,
    ST_HALT   = 4'd9
  } state_e;

  typedef enum logic [1:0] {
    MODE_NONE  = 2'd0,
    MODE_RINSE = 2'd1,
    MODE_FULL  = 2'd2,
    MODE_SPIN  = 2'd3
  } mode_e;

  // FILL through SPIN are contiguous codes, so "running" is a range test.
  function automatic logic isBusy(input state_e s);
    return (s >= ST_FILL) && (s <= ST_SPIN);
  endfunction

endpackage

// File: rtl/washer_seq_phase_timer.sv
// Down-counter for the remaining ticks of a phase; load wins over a tick,
// and the count never wraps below zero.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] loadVal_i,
  input  logic             tickEn_i,
  output logic [CNT_W-1:0] count_o,
  output logic             expire_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = loadVal_i;
    end else if (tickEn_i && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  assign expire_o = tickEn_i && (count_q == CNT_W'(1));

endmodule

// File: rtl/washer_seq.sv
// Washing-machine program sequencer: fill, agitate, drain and spin phases
// timed in ticks, with pause, emergency stop and registered drive outputs.
module washer_seq
  import washer_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int CYC_W     = 4,
  parameter int T_FILL    = 60,
  parameter int T_RUN     = 60,
  parameter int T_PAUSE   = 5,
  parameter int T_DRAIN   = 60,
  parameter int T_SPIN    = 60,
  parameter int WASH_CYC  = 7,
  parameter int RINSE_CYC = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             start,
  input  logic             pause,
  input  logic             estop,
  input  logic [1:0]       mode,
  output logic             inlet,
  output logic             drain,
  output logic             spin,
  output logic             fwd,
  output logic             rev,
  output logic             idle_led,
  output logic             busy,
  output logic             alarm,
  output logic             fault,
  output logic [3:0]       state,
  output logic [CYC_W-1:0] cyc_left,
  output logic [CNT_W-1:0] sec_left
);

  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int CYC_MAX = (1 << CYC_W) - 1;

  if (T_FILL < 1 || T_FILL > CNT_MAX || T_RUN < 1 || T_RUN > CNT_MAX ||
      T_PAUSE < 1 || T_PAUSE > CNT_MAX || T_DRAIN < 1 || T_DRAIN > CNT_MAX ||
      T_SPIN < 1 || T_SPIN > CNT_MAX || WASH_CYC < 1 || WASH_CYC > CYC_MAX ||
      RINSE_CYC < 1 || RINSE_CYC > CYC_MAX) begin : g_badParam
    $error("washer_seq: duration or cycle parameter is zero or too wide");
  end

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic             rinsePass_q, rinsePass_d;
  logic [CYC_W-1:0] cycLeft_q, cycLeft_d;
  logic             timerLoad;
  logic [CNT_W-1:0] timerVal;
  logic             tickEn;
  logic             expire;
  logic [CNT_W-1:0] secLeft;
  logic             busyNow;

  logic inlet_q, drain_q, spin_q, fwd_q, rev_q, idleLed_q, busy_q, alarm_q, fault_q;
  logic inlet_d, drain_d, spin_d, fwd_d, rev_d, idleLed_d, busy_d, alarm_d, fault_d;

  assign busyNow = isBusy(state_q);
  assign tickEn  = tick && busyNow && !pause && !estop;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (timerLoad),
    .loadVal_i (timerVal),
    .tickEn_i  (tickEn),
    .count_o   (secLeft),
    .expire_o  (expire)
  );

  // Every phase change reloads the timer; a full program passes FILL/DRAIN twice,
  // with rinsePass telling the rinse half apart from the wash half.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    rinsePass_d = rinsePass_q;
    cycLeft_d   = cycLeft_q;
    timerLoad   = 1'b0;
    timerVal    = '0;
    if (estop && (state_q != ST_IDLE)) begin
      state_d = ST_HALT;
    end else if (pause && busyNow) begin
      state_d = state_q;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start && (mode_e'(mode) != MODE_NONE)) begin
            mode_d      = mode_e'(mode);
            rinsePass_d = 1'b0;
            timerLoad   = 1'b1;
            if (mode_e'(mode) == MODE_SPIN) begin
              state_d  = ST_DRAIN;
              timerVal = CNT_W'(T_DRAIN);
            end else begin
              state_d  = ST_FILL;
              timerVal = CNT_W'(T_FILL);
            end
          end
        end
        ST_FILL: begin
          if (expire) begin
            state_d   = ST_REST_A;
            timerLoad = 1'b1;
            timerVal  = CNT_W'(T_PAUSE);
            cycLeft_d = (mode_q == MODE_FULL && !rinsePass_q) ? CYC_W'(WASH_CYC)
                                                               : CYC_W'(RINSE_CYC);
          end
        end
        ST_REST_A: begin
          if (expire) begin
            state_d   = ST_FWD;
            timerLoad = 1'b1;
            timerVal  = CNT_W'(T_RUN);
          end
        end
        ST_FWD: begin
          if (expire) begin
            state_d   = ST_REST_B;
            timerLoad = 1'b1;
            timerVal  = CNT_W'(T_PAUSE);
          end
        end
        ST_REST_B: begin
          if (expire) begin
            state_d   = ST_REV;
            timerLoad = 1'b1;
            timerVal  = CNT_W'(T_RUN);
          end
        end
        ST_REV: begin
          if (expire) begin
            cycLeft_d = cycLeft_q - CYC_W'(1);
            timerLoad = 1'b1;
            if (cycLeft_q == CYC_W'(1)) begin
              state_d  = ST_DRAIN;
              timerVal = CNT_W'(T_DRAIN);
            end else begin
              state_d  = ST_REST_A;
              timerVal = CNT_W'(T_PAUSE);
            end
          end
        end
        ST_DRAIN: begin
          if (expire) begin
            timerLoad = 1'b1;
            if (mode_q == MODE_FULL && !rinsePass_q) begin
              state_d     = ST_FILL;
              rinsePass_d = 1'b1;
              timerVal    = CNT_W'(T_FILL);
            end else if (mode_q == MODE_RINSE) begin
              state_d = ST_DONE;
            end else begin
              state_d  = ST_SPIN;
              timerVal = CNT_W'(T_SPIN);
            end
          end
        end
        ST_SPIN: begin
          if (expire) begin
            state_d   = ST_DONE;
            timerLoad = 1'b1;
          end
        end
        ST_DONE: begin
          if (start) begin
            state_d     = ST_IDLE;
            mode_d      = MODE_NONE;
            rinsePass_d = 1'b0;
          end
        end
        ST_HALT: begin
          if (start) begin
            state_d     = ST_IDLE;
            mode_d      = MODE_NONE;
            rinsePass_d = 1'b0;
            cycLeft_d   = '0;
            timerLoad   = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Drive outputs follow the registered state one cycle later; pause and estop
  // kill every actuator regardless of phase.
  always_comb begin
    inlet_d = 1'b0;
    drain_d = 1'b0;
    spin_d  = 1'b0;
    fwd_d   = 1'b0;
    rev_d   = 1'b0;
    unique case (state_q)
      ST_FILL:  inlet_d = 1'b1;
      ST_FWD:   fwd_d   = 1'b1;
      ST_REV:   rev_d   = 1'b1;
      ST_DRAIN: drain_d = 1'b1;
      ST_SPIN: begin
        drain_d = 1'b1;
        spin_d  = 1'b1;
      end
      default: begin
        inlet_d = 1'b0;
      end
    endcase
    if (pause || estop) begin
      inlet_d = 1'b0;
      drain_d = 1'b0;
      spin_d  = 1'b0;
      fwd_d   = 1'b0;
      rev_d   = 1'b0;
    end
    idleLed_d = (state_q == ST_IDLE);
    busy_d    = busyNow;
    alarm_d   = (state_q == ST_DONE);
    fault_d   = (state_q == ST_HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_NONE;
      rinsePass_q <= 1'b0;
      cycLeft_q   <= '0;
      inlet_q     <= 1'b0;
      drain_q     <= 1'b0;
      spin_q      <= 1'b0;
      fwd_q       <= 1'b0;
      rev_q       <= 1'b0;
      idleLed_q   <= 1'b1;
      busy_q      <= 1'b0;
      alarm_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      rinsePass_q <= rinsePass_d;
      cycLeft_q   <= cycLeft_d;
      inlet_q     <= inlet_d;
      drain_q     <= drain_d;
      spin_q      <= spin_d;
      fwd_q       <= fwd_d;
      rev_q       <= rev_d;
      idleLed_q   <= idleLed_d;
      busy_q      <= busy_d;
      alarm_q     <= alarm_d;
      fault_q     <= fault_d;
    end
  end

  assign inlet    = inlet_q;
  assign drain    = drain_q;
  assign spin     = spin_q;
  assign fwd      = fwd_q;
  assign rev      = rev_q;
  assign idle_led = idleLed_q;
  assign busy     = busy_q;
  assign alarm    = alarm_q;
  assign fault    = fault_q;
  assign state    = state_q;
  assign cyc_left = cycLeft_q;
  assign sec_left = secLeft;

endmodule
